// File: rtl/fir_requant_decim.sv
`default_nettype none
// ============================================================================
//  Module      : fir_requant_decim
//  Description : FIR output stage. Rounds and right-shifts the full-precision
//                sample, saturates it to WIDTH_O bits, keeps every D-th valid
//                sample and buffers kept samples in a small FIFO behind a
//                valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_requant_decim #(
  parameter int WIDTH_Y = 20,
  parameter int WIDTH_O = 8,
  parameter int SHIFT   = 8,
  parameter int D       = 2,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clr,
  input  logic                      y_valid,
  input  logic signed [WIDTH_Y-1:0] y,
  output logic signed [WIDTH_O-1:0] m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      overflow,
  output logic [15:0]               sat_count
);

  // Phase counter needs at least one bit even when D == 1.
  localparam int c_pw = (D > 1) ? $clog2(D) : 1;
  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_pw-1:0] c_plast = c_pw'(D - 1);
  localparam logic signed [WIDTH_Y:0] c_omax = (WIDTH_Y + 1)'((1 << (WIDTH_O - 1)) - 1);
  localparam logic signed [WIDTH_Y:0] c_omin = ~c_omax;

  logic [c_pw-1:0]           r_phase;
  logic                      w_keep;
  logic signed [WIDTH_Y:0]   w_ext;
  logic signed [WIDTH_Y:0]   w_r;
  logic signed [WIDTH_O-1:0] w_q;
  logic                      w_sat;

  logic                      r_stg_valid;
  logic signed [WIDTH_O-1:0] r_stg_data;
  logic                      r_stg_sat;

  logic signed [WIDTH_O-1:0] r_mem [DEPTH];
  logic [c_aw:0]             r_wptr;
  logic [c_aw:0]             r_rptr;
  logic signed [WIDTH_O-1:0] r_hold;
  logic                      r_overflow;
  logic [15:0]               r_sat_count;

  logic                      w_empty;
  logic                      w_full;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_drop;

  assign w_keep = y_valid && (r_phase == '0);

  // Phase advances on every valid input and wraps after D samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase <= '0;
    end else if (clr) begin
      r_phase <= '0;
    end else if (y_valid) begin
      r_phase <= (r_phase == c_plast) ? '0 : r_phase + c_pw'(1);
    end
  end

  // Sign-extend by one bit so the rounding add cannot wrap.
  assign w_ext = {y[WIDTH_Y-1], y};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [WIDTH_Y:0] c_half = (WIDTH_Y + 1)'(1) << (SHIFT - 1);
      // Adding half an LSB then flooring rounds ties toward +inf.
      assign w_r = (w_ext + c_half) >>> SHIFT;
    end else begin : g_pass
      assign w_r = w_ext;
    end
  endgenerate

  // Clamp the rounded value to the signed output range and flag clipping.
  always_comb begin
    w_sat = 1'b0;
    w_q   = w_r[WIDTH_O-1:0];
    if (w_r > c_omax) begin
      w_q   = {1'b0, {(WIDTH_O - 1){1'b1}}};
      w_sat = 1'b1;
    end else if (w_r < c_omin) begin
      w_q   = {1'b1, {(WIDTH_O - 1){1'b0}}};
      w_sat = 1'b1;
    end
  end

  // Stage register holds one kept sample for a single cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stg_valid <= 1'b0;
      r_stg_data  <= '0;
      r_stg_sat   <= 1'b0;
    end else if (clr) begin
      r_stg_valid <= 1'b0;
      r_stg_data  <= '0;
      r_stg_sat   <= 1'b0;
    end else begin
      r_stg_valid <= w_keep;
      if (w_keep) begin
        r_stg_data <= w_q;
        r_stg_sat  <= w_sat;
      end
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                   (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
  assign w_pop   = !w_empty && m_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign w_push  = r_stg_valid && (!w_full || w_pop);
  assign w_drop  = r_stg_valid && w_full && !w_pop;

  // Storage array; contents are only observed while non-empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[c_aw-1:0]] <= r_stg_data;
    end
  end

  // Pointers, last-popped value, sticky overflow and saturation counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_hold      <= '0;
      r_overflow  <= 1'b0;
      r_sat_count <= '0;
    end else if (clr) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_hold      <= '0;
      r_overflow  <= 1'b0;
      r_sat_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (c_aw + 1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (c_aw + 1)'(1);
        r_hold <= r_mem[r_rptr[c_aw-1:0]];
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (r_stg_valid && r_stg_sat && (r_sat_count != 16'hFFFF)) begin
        r_sat_count <= r_sat_count + 16'd1;
      end
    end
  end

  // Show the head while non-empty, otherwise the last value handed out.
  assign m_data    = w_empty ? r_hold : r_mem[r_rptr[c_aw-1:0]];
  assign m_valid   = !w_empty;
  assign overflow  = r_overflow;
  assign sat_count = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_fir_requant_decim.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_requant_decim
//  Description : Self-checking bench for fir_requant_decim. Two instances
//                (D=2 and D=3) are checked every cycle against a queue-based
//                model, plus directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_requant_decim;

  logic clk;
  logic rstn;
  logic clr;

  logic               yv0, yv1;
  logic signed [19:0] y0, y1;
  logic               mr0, mr1;
  logic signed [7:0]  md0, md1;
  logic               mv0, mv1;
  logic               of0, of1;
  logic [15:0]        sc0, sc1;

  int errors = 0;
  int checks = 0;

  fir_requant_decim u_dut0 (
    .clk(clk), .rstn(rstn), .clr(clr), .y_valid(yv0), .y(y0),
    .m_data(md0), .m_valid(mv0), .m_ready(mr0), .overflow(of0), .sat_count(sc0)
  );

  fir_requant_decim #(.D(3)) u_dut1 (
    .clk(clk), .rstn(rstn), .clr(clr), .y_valid(yv1), .y(y1),
    .m_data(md1), .m_valid(mv1), .m_ready(mr1), .overflow(of1), .sat_count(sc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference requantizer for SHIFT=8, WIDTH_O=8: floor((y+128)/256), clamped.
  function automatic int rq(input int yy, output bit s);
    real r;
    int  v;
    r = $floor((real'(yy) + 128.0) / 256.0);
    v = int'(r);
    s = 1'b0;
    if (v > 127) begin
      v = 127;
      s = 1'b1;
    end else if (v < -128) begin
      v = -128;
      s = 1'b1;
    end
    return v;
  endfunction

  // ---------------- behavioural model state (index 0: D=2, 1: D=3) --------
  int  dv [2] = '{2, 3};
  int  mq [2][$];
  int  hold [2];
  bit  sv [2];
  int  sval [2];
  bit  ssat [2];
  int  cnt [2];
  bit  ovf [2];
  int  sc [2];
  int  got0 [$];
  int  got1 [$];

  bit  cv [2];
  int  cy [2];
  bit  cr [2];
  bit  crst;

  // Model update and per-cycle comparison against both instances.
  always @(posedge clk) begin
    cv[0] = yv0;  cy[0] = int'(y0);  cr[0] = mr0;
    cv[1] = yv1;  cy[1] = int'(y1);  cr[1] = mr1;
    crst  = !rstn || clr;
    if (!crst && mv0 && mr0) got0.push_back(int'(md0));
    if (!crst && mv1 && mr1) got1.push_back(int'(md1));
    #1;
    for (int n = 0; n < 2; n++) begin
      bit s;
      int ev;
      if (crst) begin
        cnt[n] = 0; sv[n] = 1'b0; mq[n].delete(); hold[n] = 0;
        ovf[n] = 1'b0; sc[n] = 0;
      end else begin
        if (mq[n].size() > 0 && cr[n]) hold[n] = mq[n].pop_front();
        if (sv[n]) begin
          if (ssat[n] && sc[n] < 65535) sc[n]++;
          if (mq[n].size() < 4) mq[n].push_back(sval[n]);
          else ovf[n] = 1'b1;
        end
        sv[n] = 1'b0;
        if (cv[n]) begin
          if (cnt[n] % dv[n] == 0) begin
            sv[n]   = 1'b1;
            sval[n] = rq(cy[n], s);
            ssat[n] = s;
          end
          cnt[n]++;
        end
      end
      ev = (mq[n].size() > 0) ? mq[n][0] : hold[n];
      check($sformatf("m_valid[%0d]", n), (n == 0) ? int'(mv0) : int'(mv1), int'(mq[n].size() > 0));
      check($sformatf("m_data[%0d]", n), (n == 0) ? int'(md0) : int'(md1), ev);
      check($sformatf("overflow[%0d]", n), (n == 0) ? int'(of0) : int'(of1), int'(ovf[n]));
      check($sformatf("sat_count[%0d]", n), (n == 0) ? int'(sc0) : int'(sc1), sc[n]);
    end
  end

  // One valid cycle on instance 0, returns 2 ns after the sampling edge.
  task automatic s0(input int v);
    @(posedge clk); #2;
    yv0 = 1'b1; y0 = 20'(v);
    @(posedge clk); #2;
    yv0 = 1'b0;
  endtask

  // Kept sample followed by a discarded filler so the D=2 phase returns to 0.
  task automatic kept0(input int v);
    s0(v);
    s0(12345);
  endtask

  // Kept sample with latency and value check (FIFO drained beforehand).
  task automatic round0(input int v, input int exp);
    s0(v);
    check("latency1_m_valid", int'(mv0), 0);
    @(posedge clk); #2;
    check("latency2_m_valid", int'(mv0), 1);
    check($sformatf("value_y%0d", v), int'(md0), exp);
    s0(12345);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; clr = 1'b0;
    yv0 = 1'b0; y0 = '0; mr0 = 1'b1;
    yv1 = 1'b0; y1 = '0; mr1 = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("reset_m_valid", int'(mv0), 0);
    check("reset_m_data", int'(md0), 0);
    check("reset_overflow", int'(of0), 0);
    check("reset_sat_count", int'(sc0), 0);
    rstn = 1'b1;

    // Rounding and saturation
    round0(383, 1);
    round0(384, 2);
    round0(-384, -1);
    round0(-385, -2);
    round0(40000, 127);
    round0(-40000, -128);
    round0(32639, 127);
    repeat (2) @(posedge clk);
    #2;
    check("sat_count_total", int'(sc0), 2);

    // Decimation by 3, continuous then gapped
    got1.delete();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #2;
      yv1 = 1'b1; y1 = 20'(256 * i);
    end
    @(posedge clk); #2;
    yv1 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("dec_cont_count", got1.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("dec_cont_%0d", i), (got1.size() > i) ? got1[i] : -999, 3 * i);
    got1.delete();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #2;
      yv1 = 1'b1; y1 = 20'(256 * i);
      @(posedge clk); #2;
      yv1 = 1'b0;
    end
    repeat (4) @(posedge clk);
    #2;
    check("dec_gap_count", got1.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("dec_gap_%0d", i), (got1.size() > i) ? got1[i] : -999, 3 * i);

    // Backpressure: six kept samples into a four-deep FIFO
    @(posedge clk); #2;
    mr0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      kept0(256 * (10 + k));
      if (k == 3) check("bp_overflow_after4", int'(of0), 0);
      if (k == 4) check("bp_overflow_after5", int'(of0), 1);
    end
    check("bp_m_valid", int'(mv0), 1);
    check("bp_head_held", int'(md0), 10);
    got0.delete();
    mr0 = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    check("bp_drain_count", got0.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_drain_%0d", i), (got0.size() > i) ? got0[i] : -999, 10 + i);
    check("bp_empty_hold", int'(md0), 13);
    check("bp_overflow_sticky", int'(of0), 1);

    // Clear before the full-with-pop case
    clr = 1'b1;
    @(posedge clk); #2;
    clr = 1'b0;
    check("clr1_overflow", int'(of0), 0);

    // Full FIFO with a simultaneous pop: kept sample is not dropped
    mr0 = 1'b0;
    for (int k = 0; k < 4; k++) kept0(256 * (20 + k));
    check("full_m_valid", int'(mv0), 1);
    check("full_head", int'(md0), 20);
    @(posedge clk); #2;
    yv0 = 1'b1; y0 = 20'(256 * 24);
    @(posedge clk); #2;
    yv0 = 1'b0; mr0 = 1'b1;
    @(posedge clk); #2;
    mr0 = 1'b0;
    check("fullpop_overflow", int'(of0), 0);
    check("fullpop_head", int'(md0), 21);
    s0(12345);
    got0.delete();
    mr0 = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    check("fullpop_count", got0.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("fullpop_drain_%0d", i), (got0.size() > i) ? got0[i] : -999, 21 + i);

    // Asynchronous reset with three entries stored
    mr0 = 1'b0;
    kept0(256 * 30);
    kept0(40000);
    kept0(256 * 31);
    check("pre_rst_sat_count", int'(sc0), 1);
    check("pre_rst_m_valid", int'(mv0), 1);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("rst_m_valid", int'(mv0), 0);
    check("rst_overflow", int'(of0), 0);
    check("rst_sat_count", int'(sc0), 0);
    check("rst_m_data", int'(md0), 0);
    @(posedge clk); #2;
    rstn = 1'b1; mr0 = 1'b1;
    round0(256 * 5, 5);

    // Synchronous clear with three entries stored
    mr0 = 1'b0;
    kept0(256 * 33);
    kept0(40000);
    kept0(256 * 34);
    @(posedge clk); #2;
    clr = 1'b1;
    #1;
    check("clr_before_edge_m_valid", int'(mv0), 1);
    @(posedge clk); #2;
    clr = 1'b0;
    check("clr_m_valid", int'(mv0), 0);
    check("clr_overflow", int'(of0), 0);
    check("clr_sat_count", int'(sc0), 0);
    check("clr_m_data", int'(md0), 0);
    mr0 = 1'b1;
    round0(256 * 7, 7);

    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
